// File: rtl/nonce_result_fifo.sv
// nonce_result_fifo: show-ahead FIFO of winning nonces with saturating attempt/hit/drop stats
module nonce_result_fifo #(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              complete,
    input  logic              found,
    input  logic [31:0]       nonce,
    input  logic [31:0]       hash_top,
    input  logic              clear,
    input  logic              pop,
    output logic [31:0]       head_nonce,
    output logic [31:0]       head_hash,
    output logic              empty,
    output logic              full,
    output logic [PTR_W:0]    level,
    output logic              overflow,
    output logic              underflow,
    output logic [STAT_W-1:0] attempt_cnt,
    output logic [STAT_W-1:0] hit_cnt,
    output logic [STAT_W-1:0] drop_cnt
);
    logic [63:0]       mem_q [DEPTH];
    logic [63:0]       mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    level_q, level_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic [STAT_W-1:0] attempt_q, attempt_d, hit_q, hit_d, drop_q, drop_d;
    logic              push_req, do_push, do_pop, do_drop;

    assign empty    = level_q == '0;
    assign full     = level_q == (PTR_W+1)'(DEPTH);
    assign push_req = complete & found;
    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign do_push  = push_req & (~full | pop);
    assign do_pop   = pop & ~empty;
    assign do_drop  = push_req & full & ~pop;

    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        attempt_d   = attempt_q;
        hit_d       = hit_q;
        drop_d      = drop_q;
        if (clear) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            attempt_d   = '0;
            hit_d       = '0;
            drop_d      = '0;
        end else begin
            if (do_push) mem_d[wr_ptr_q] = {nonce, hash_top};
            wr_ptr_d    = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_d    = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            level_d     = level_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
            overflow_d  = overflow_q | do_drop;
            underflow_d = underflow_q | (pop & empty);
            attempt_d   = (complete && attempt_q != '1) ? attempt_q + STAT_W'(1) : attempt_q;
            hit_d       = (do_push && hit_q != '1) ? hit_q + STAT_W'(1) : hit_q;
            drop_d      = (do_drop && drop_q != '1) ? drop_q + STAT_W'(1) : drop_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_q       <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            attempt_q   <= '0;
            hit_q       <= '0;
            drop_q      <= '0;
        end else begin
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            attempt_q   <= attempt_d;
            hit_q       <= hit_d;
            drop_q      <= drop_d;
        end
    end

    assign {head_nonce, head_hash} = mem_q[rd_ptr_q];
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign attempt_cnt = attempt_q;
    assign hit_cnt     = hit_q;
    assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_nonce_result_fifo.sv
// tb_nonce_result_fifo: directed checks of the result FIFO and its saturating statistics
module tb_nonce_result_fifo;
    logic        clk = 1'b0, n_rst = 1'b0;
    logic        complete = 1'b0, found = 1'b0, clear = 1'b0, pop = 1'b0;
    logic [31:0] nonce = '0, hash_top = '0;
    logic [31:0] head_nonce, head_hash, attempt_cnt, hit_cnt, drop_cnt;
    logic        empty, full, overflow, underflow;
    logic [3:0]  level;
    logic [31:0] s_head_nonce, s_head_hash;
    logic        s_empty, s_full, s_overflow, s_underflow;
    logic [3:0]  s_level, s_attempt_cnt, s_hit_cnt, s_drop_cnt;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    nonce_result_fifo dut (
        .clk(clk), .n_rst(n_rst), .complete(complete), .found(found), .nonce(nonce),
        .hash_top(hash_top), .clear(clear), .pop(pop), .head_nonce(head_nonce),
        .head_hash(head_hash), .empty(empty), .full(full), .level(level),
        .overflow(overflow), .underflow(underflow), .attempt_cnt(attempt_cnt),
        .hit_cnt(hit_cnt), .drop_cnt(drop_cnt)
    );

    nonce_result_fifo #(.STAT_W(4)) dut_s (
        .clk(clk), .n_rst(n_rst), .complete(complete), .found(found), .nonce(nonce),
        .hash_top(hash_top), .clear(clear), .pop(pop), .head_nonce(s_head_nonce),
        .head_hash(s_head_hash), .empty(s_empty), .full(s_full), .level(s_level),
        .overflow(s_overflow), .underflow(s_underflow), .attempt_cnt(s_attempt_cnt),
        .hit_cnt(s_hit_cnt), .drop_cnt(s_drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic f, input logic [31:0] n,
                         input logic [31:0] h, input logic p);
        complete = c; found = f; nonce = n; hash_top = h; pop = p;
        step();
        complete = 0; found = 0; pop = 0;
    endtask

    initial begin
        repeat (2) step();
        n_rst = 1'b1;
        repeat (5) step();
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);
        chk("rst_att", attempt_cnt, 0);
        chk("rst_hit", hit_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_head", head_nonce, 0);

        repeat (3) drive(1, 0, 32'h99, 32'h99, 0);
        chk("miss_att", attempt_cnt, 3);
        chk("miss_hit", hit_cnt, 0);
        chk("miss_empty", 32'(empty), 1);

        drive(1, 1, 32'h1234, 32'hAB, 0);
        chk("one_nonce", head_nonce, 32'h1234);
        chk("one_hash", head_hash, 32'hAB);
        chk("one_level", 32'(level), 1);
        chk("one_empty", 32'(empty), 0);
        chk("one_hit", hit_cnt, 1);
        drive(0, 0, 0, 0, 1);
        chk("pop_empty", 32'(empty), 1);
        chk("pop_level", 32'(level), 0);

        for (int i = 1; i <= 9; i++) drive(1, 1, 32'(i), 32'h100 + 32'(i), 0);
        chk("fill_full", 32'(full), 1);
        chk("fill_level", 32'(level), 8);
        chk("fill_drop", drop_cnt, 1);
        chk("fill_ovf", 32'(overflow), 1);
        chk("fill_hit", hit_cnt, 9);
        chk("fill_att", attempt_cnt, 13);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain_n%0d", i), head_nonce, 32'(i));
            chk($sformatf("drain_h%0d", i), head_hash, 32'h100 + 32'(i));
            drive(0, 0, 0, 0, 1);
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_level", 32'(level), 0);

        for (int i = 1; i <= 8; i++) drive(1, 1, 32'(i), 32'h200 + 32'(i), 0);
        drive(1, 1, 32'hA, 32'h20A, 1);
        chk("pp_level", 32'(level), 8);
        chk("pp_drop", drop_cnt, 1);
        chk("pp_head", head_nonce, 2);
        chk("pp_hit", hit_cnt, 18);
        for (int i = 2; i <= 9; i++) begin
            chk($sformatf("pp_drain%0d", i), head_nonce, i == 9 ? 32'hA : 32'(i));
            drive(0, 0, 0, 0, 1);
        end
        chk("pp_empty", 32'(empty), 1);
        chk("unf_pre", 32'(underflow), 0);
        drive(0, 0, 0, 0, 1);
        chk("unf_set", 32'(underflow), 1);
        chk("unf_level", 32'(level), 0);

        drive(1, 1, 32'h55, 32'h66, 1);
        chk("pe_level", 32'(level), 1);
        chk("pe_head", head_nonce, 32'h55);
        chk("pe_hit", hit_cnt, 19);
        drive(0, 0, 0, 0, 1);

        clear = 1; step(); clear = 0;
        chk("clr_att", attempt_cnt, 0);
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_unf", 32'(underflow), 0);
        chk("clr_s_att", 32'(s_attempt_cnt), 0);
        repeat (15) drive(1, 0, 0, 0, 0);
        chk("sat_s15", 32'(s_attempt_cnt), 15);
        drive(1, 0, 0, 0, 0);
        chk("sat_s_hold", 32'(s_attempt_cnt), 15);
        chk("sat_main", attempt_cnt, 16);

        clear = 1;
        drive(1, 1, 32'h77, 32'h88, 0);
        clear = 0;
        chk("cp_att", attempt_cnt, 0);
        chk("cp_s_att", 32'(s_attempt_cnt), 0);
        chk("cp_hit", hit_cnt, 0);
        chk("cp_level", 32'(level), 0);
        chk("cp_empty", 32'(empty), 1);
        step();
        chk("cp_level2", 32'(level), 0);

        drive(1, 1, 32'hBEEF, 32'hCAFE, 0);
        chk("mr_level", 32'(level), 1);
        n_rst = 0;
        #1;
        chk("mr_empty", 32'(empty), 1);
        chk("mr_head", head_nonce, 0);
        chk("mr_hit", hit_cnt, 0);
        step();
        n_rst = 1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
